// File: rtl/pic_8259_pkg.sv
// Shared definitions for the 8259A command sequencer:
// init-sequence states, OCW2 command codes and ICW/OCW bit positions.
package pic_8259_pkg;

    typedef enum logic [1:0] {
        READY     = 2'd0,
        WAIT_ICW2 = 2'd1,
        WAIT_ICW3 = 2'd2,
        WAIT_ICW4 = 2'd3
    } seq_state_t;

    // OCW2 R/SL/EOI command codes
    localparam logic [2:0] OCW2_AEOI_ROT_CLR  = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI        = 3'b001;
    localparam logic [2:0] OCW2_NOP           = 3'b010;
    localparam logic [2:0] OCW2_SPEC_EOI      = 3'b011;
    localparam logic [2:0] OCW2_AEOI_ROT_SET  = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI    = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIORITY  = 3'b110;
    localparam logic [2:0] OCW2_ROT_SPEC_EOI  = 3'b111;

    localparam int ICW1_LTIM = 3;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_IC4  = 0;

    localparam int ICW4_SFNM = 4;
    localparam int ICW4_BUF  = 3;
    localparam int ICW4_MS   = 2;
    localparam int ICW4_AEOI = 1;

    localparam int OCW3_ESMM = 6;
    localparam int OCW3_SMM  = 5;
    localparam int OCW3_P    = 2;
    localparam int OCW3_RR   = 1;
    localparam int OCW3_RIS  = 0;

endpackage

// File: rtl/interrupt_command_sequencer.sv
// 8259A ICW1..ICW4 init sequencer and OCW register file.
// Emits one-cycle OCW2 and poll pulses to the resolver/ISR logic.
module interrupt_command_sequencer
    import pic_8259_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       write_initial_command_word_1,
    input  logic       write_a0_high,
    input  logic       write_operation_control_word_2,
    input  logic       write_operation_control_word_3,
    input  logic [7:0] internal_data_bus,
    output logic       init_done,
    output logic       level_or_edge_triggered,
    output logic       single_mode,
    output logic [4:0] vector_base,
    output logic [7:0] cascade_config,
    output logic       auto_eoi,
    output logic       buffered_mode,
    output logic       buffered_master,
    output logic       special_fully_nested,
    output logic [7:0] interrupt_mask,
    output logic       special_mask_mode,
    output logic       read_isr_select,
    output logic       poll_command,
    output logic       ocw2_strobe,
    output logic [2:0] ocw2_command,
    output logic [2:0] ocw2_level,
    output logic       rotate_on_auto_eoi
);

    seq_state_t state, state_next;
    logic       ic4;
    logic       do_icw1, do_a0, do_ocw2, do_ocw3;
    logic       enter_ready;

    // Strobe priority: ICW1 > A0=1 > OCW2 > OCW3
    always_comb begin
        do_icw1 = write_initial_command_word_1;
        do_a0   = !do_icw1 && write_a0_high;
        do_ocw2 = !do_icw1 && !write_a0_high
                  && write_operation_control_word_2
                  && (state == READY);
        do_ocw3 = !do_icw1 && !write_a0_high
                  && !write_operation_control_word_2
                  && write_operation_control_word_3
                  && (state == READY);
    end

    always_comb begin
        state_next = state;
        if (do_icw1) begin
            state_next = WAIT_ICW2;
        end else if (do_a0) begin
            case (state)
                WAIT_ICW2: begin
                    if (!single_mode)
                        state_next = WAIT_ICW3;
                    else if (ic4)
                        state_next = WAIT_ICW4;
                    else
                        state_next = READY;
                end
                WAIT_ICW3: state_next = ic4 ? WAIT_ICW4 : READY;
                WAIT_ICW4: state_next = READY;
                default:   state_next = state;
            endcase
        end
        enter_ready = (state != READY) && (state_next == READY);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= READY;
        else
            state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            init_done               <= 1'b0;
            level_or_edge_triggered <= 1'b0;
            single_mode             <= 1'b0;
            ic4                     <= 1'b0;
            vector_base             <= 5'd0;
            cascade_config          <= 8'h00;
            auto_eoi                <= 1'b0;
            buffered_mode           <= 1'b0;
            buffered_master         <= 1'b0;
            special_fully_nested    <= 1'b0;
            interrupt_mask          <= 8'hFF;
            special_mask_mode       <= 1'b0;
            read_isr_select         <= 1'b0;
            poll_command            <= 1'b0;
            ocw2_strobe             <= 1'b0;
            ocw2_command            <= 3'd0;
            ocw2_level              <= 3'd0;
            rotate_on_auto_eoi      <= 1'b0;
        end else begin
            ocw2_strobe  <= 1'b0;
            poll_command <= 1'b0;
            if (do_icw1) begin
                level_or_edge_triggered <= internal_data_bus[ICW1_LTIM];
                single_mode             <= internal_data_bus[ICW1_SNGL];
                ic4                     <= internal_data_bus[ICW1_IC4];
                interrupt_mask          <= 8'h00;
                special_mask_mode       <= 1'b0;
                read_isr_select         <= 1'b0;
                rotate_on_auto_eoi      <= 1'b0;
                auto_eoi                <= 1'b0;
                buffered_mode           <= 1'b0;
                buffered_master         <= 1'b0;
                special_fully_nested    <= 1'b0;
                cascade_config          <= 8'h00;
                init_done               <= 1'b0;
            end else if (do_a0) begin
                unique case (state)
                    WAIT_ICW2: vector_base <= internal_data_bus[7:3];
                    WAIT_ICW3: cascade_config <= internal_data_bus;
                    WAIT_ICW4: begin
                        special_fully_nested <= internal_data_bus[ICW4_SFNM];
                        buffered_mode        <= internal_data_bus[ICW4_BUF];
                        buffered_master      <= internal_data_bus[ICW4_MS];
                        auto_eoi             <= internal_data_bus[ICW4_AEOI];
                    end
                    READY: interrupt_mask <= internal_data_bus;
                endcase
                if (enter_ready)
                    init_done <= 1'b1;
            end else if (do_ocw2) begin
                ocw2_command <= internal_data_bus[7:5];
                ocw2_level   <= internal_data_bus[2:0];
                ocw2_strobe  <= 1'b1;
                if (internal_data_bus[7:5] == OCW2_AEOI_ROT_SET)
                    rotate_on_auto_eoi <= 1'b1;
                else if (internal_data_bus[7:5] == OCW2_AEOI_ROT_CLR)
                    rotate_on_auto_eoi <= 1'b0;
            end else if (do_ocw3) begin
                if (internal_data_bus[OCW3_ESMM])
                    special_mask_mode <= internal_data_bus[OCW3_SMM];
                if (internal_data_bus[OCW3_RR])
                    read_isr_select <= internal_data_bus[OCW3_RIS];
                poll_command <= internal_data_bus[OCW3_P];
            end
        end
    end

endmodule

// File: doc/interrupt_command_sequencer.md
# interrupt_command_sequencer

Downstream of the 8259A bus control logic: consumes its decoded write strobes plus the internal data bus and runs the ICW1→ICW2→ICW3→ICW4 initialization sequence. It holds every programmed configuration field (ICW contents, OCW1 mask, OCW3 modes) as registers. It issues one-cycle OCW2/poll command pulses to the priority resolver and in-service logic.

## Interface
Parameters: none.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; all registers take reset values immediately
- write_initial_command_word_1  in  1  one-cycle strobe: A0=0, D4=1 write
- write_a0_high  in  1  one-cycle strobe: A0=1 write (ICW2/ICW3/ICW4/OCW1 by state)
- write_operation_control_word_2  in  1  one-cycle strobe: A0=0, D4=0, D3=0
- write_operation_control_word_3  in  1  one-cycle strobe: A0=0, D4=0, D3=1
- internal_data_bus  in  8  written byte, valid while any strobe is high
- init_done  out  1  sequence complete (state READY after at least one ICW1)
- level_or_edge_triggered  out  1  ICW1.D3 (LTIM)
- single_mode  out  1  ICW1.D1 (SNGL)
- vector_base  out  5  ICW2.D7:3
- cascade_config  out  8  ICW3 byte
- auto_eoi  out  1  ICW4.D1
- buffered_mode  out  1  ICW4.D3
- buffered_master  out  1  ICW4.D2
- special_fully_nested  out  1  ICW4.D4
- interrupt_mask  out  8  OCW1 byte
- special_mask_mode  out  1  OCW3 SMM latch
- read_isr_select  out  1  1=ISR, 0=IRR on status read
- poll_command  out  1  one-cycle pulse, OCW3.P=1
- ocw2_strobe  out  1  one-cycle pulse per accepted OCW2
- ocw2_command  out  3  OCW2.D7:5 (R, SL, EOI), held
- ocw2_level  out  3  OCW2.D2:0, held
- rotate_on_auto_eoi  out  1  auto-rotate latch

## Operation
- States: READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4. Reset → READY, init_done=0.
- Reset values: all outputs 0 except interrupt_mask=8'hFF.
- ICW1 strobe, any state: latch LTIM/SNGL/IC4 (IC4 internal); clear interrupt_mask to 8'h00, special_mask_mode, read_isr_select, rotate_on_auto_eoi; clear all ICW4 fields, cascade_config; init_done=0; → WAIT_ICW2.
- write_a0_high:
  - WAIT_ICW2: vector_base=D7:3; → WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else READY.
  - WAIT_ICW3: cascade_config=D; → WAIT_ICW4 if IC4=1, else READY.
  - WAIT_ICW4: latch SFNM/BUF/M-S/AEOI; → READY.
  - READY: interrupt_mask=D (OCW1).
- Entry to READY from any WAIT state sets init_done=1.
- OCW2/OCW3 strobes ignored unless state READY.
- OCW2: ocw2_command=D7:5, ocw2_level=D2:0, ocw2_strobe pulses. R,SL,EOI=100 sets rotate_on_auto_eoi; 000 clears it.
- OCW3: if D6 (ESMM) then special_mask_mode=D5; if D1 (RR) then read_isr_select=D0; poll_command=D2.
- Simultaneous strobes (illegal upstream, defined here): ICW1 > write_a0_high > OCW2 > OCW3; lower ones dropped.

## Timing
- All outputs registered; value sampled at edge N with strobe high is visible after edge N.
- Pulses (ocw2_strobe, poll_command) high exactly one cycle after the sampling edge.
- Back-to-back strobes on consecutive cycles are accepted; each consumes one cycle.
- Reset asserted mid-sequence: immediate return to READY with reset values; a later A0=1 write is an OCW1.
- ICW1 during WAIT_ICW3/ICW4 restarts the sequence; partial ICW state discarded.

## Structure
- Shared package pic_8259_pkg: state enum, OCW2 command encodings (nonspecific EOI 001, specific EOI 011, rotate-on-EOI 101, set-priority 110, etc.), ICW/OCW bit-position constants.
- Single module, no sub-modules.

## Test plan
- Reset → interrupt_mask=FF, init_done=0, all else 0; A0=1 write 0x55 → interrupt_mask=55.
- ICW1=0x13 (edge, single, IC4), ICW2=0x48, ICW4=0x03 → vector_base=09, auto_eoi=1, init_done=1, ICW3 state skipped.
- ICW1=0x11 cascade, ICW2=0x20, ICW3=0x04, ICW4=0x01 → cascade_config=04; then A0=1 0xF0 → mask=F0.
- In READY: OCW2=0x63 → ocw2_strobe 1 cycle, command=011, level=3; OCW2=0x80 → rotate_on_auto_eoi=1.
- OCW3=0x6B → special_mask_mode=1, read_isr_select=1; OCW3=0x0C → poll_command pulse; OCW2 during WAIT_ICW2 → no pulse.
- Reset pulse during WAIT_ICW3 → READY, mask=FF; new ICW1 mid-WAIT_ICW4 → WAIT_ICW2, mask=00.
